game_status_ctrl: RTL and testbench
===================================

Name: game_status_ctrl

Overview:
- Game-level controller for the tile-matching game.
- Turns start/quit/match/miss event pulses into the game mode, a BCD score, a BCD countdown timer and a lives bar.
- Drives the holder inputs of the board display stage: userquit, ingameOn, gameOver, hex0hldr–hex5hldr and ledrhldr.
- Sits directly upstream of that stage; all outputs are registered.

Parameters:
TICK_DIV, 50000000, CLOCK_50 cycles per game second (legal range ≥2)
GAME_SECONDS, 60, countdown start value in seconds (legal range 1–99)
LIVES, 10, misses allowed before game over (legal range 1–10)
FLASH_DIV, 12500000, cycles per LED toggle in OVER (legal range ≥1)

Ports:
CLOCK_50  input  1  system clock; all logic on its rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, synchronous to CLOCK_50
quit  input  1  one-cycle pulse
match_pulse  input  1  one-cycle pulse: pair matched
miss_pulse  input  1  one-cycle pulse: pair mismatched
userquit  output  1  high in QUIT
ingameOn  output  1  high in PLAY
gameOver  output  1  high in OVER
hex0hldr  output  4  mode code: IDLE=0, PLAY=1, OVER=2, QUIT=3
hex2hldr  output  4  timer ones digit (BCD), 4'hF = blank
hex3hldr  output  4  timer tens digit (BCD), 4'hF = blank
hex4hldr  output  4  score ones digit (BCD), 4'hF = blank
hex5hldr  output  4  score tens digit (BCD), 4'hF = blank
ledrhldr  output  10  lives bar or flash pattern

Behaviour:
- Reset (resetn low, asynchronous):
  - State IDLE; userquit, ingameOn and gameOver all 0.
  - hex0hldr=0; hex2hldr–hex5hldr=4'hF; ledrhldr=0.
  - Score 00; lives 0; prescaler and flash counter 0.
  - Reset asserted mid-game aborts immediately with no residual state.
- Latency: an event sampled at rising edge N is reflected on all outputs right after edge N (one cycle). No combinational input-to-output paths.
- IDLE:
  - Score and timer digits blank; ledrhldr=0.
  - start → PLAY and load: score=00, timer=GAME_SECONDS (BCD), lives=LIVES, prescaler=0.
  - quit → QUIT. match/miss ignored.
- PLAY:
  - Outputs: ingameOn=1; hex5/hex4=score; hex3/hex2=timer; ledrhldr = lower `lives` bits set (thermometer).
  - Prescaler counts 0..TICK_DIV-1 and wraps. On each wrap the timer decrements by one in BCD (10→09 borrow).
  - match_pulse: score +1 in BCD, saturating at 99.
  - miss_pulse: lives −1; no further effect once lives is 0.
  - match and miss in the same cycle: both applied.
  - Exit priority, highest first:
    1. quit → QUIT (any same-cycle match/miss/tick discarded).
    2. lives becoming 0, or a tick taking the timer to 00 → OVER in the same edge. Same-cycle score update is kept. Timer 00 is latched but shown blank in OVER.
  - start in PLAY is ignored.
- OVER:
  - Outputs: gameOver=1; score held and shown; timer digits blank.
  - ledrhldr = 10'h3FF on entry, then inverts every FLASH_DIV cycles.
  - start → PLAY with fresh load (as from IDLE). quit → QUIT. match/miss ignored.
- QUIT:
  - Outputs: userquit=1; all digits blank; ledrhldr=0.
  - start → IDLE (score cleared). Other inputs ignored.
- start and quit in the same cycle: quit wins in every state except QUIT, where start is taken.
- Flash counter and prescaler clear on every state entry.

Test Plan:
- Reset: drive resetn low mid-PLAY asynchronously → outputs immediately userquit=0, ingameOn=0, gameOver=0, hex0hldr=0, hex2–hex5=F, ledrhldr=0, with no clock edge required.
- Timer (TICK_DIV=4, GAME_SECONDS=12): pulse start → next cycle hex3/hex2=1/2, ledrhldr=10'h3FF, hex0hldr=1. After 4 cycles → 1/1; after 12 → 0/9; 48 cycles after start → gameOver=1, hex0hldr=2, timer digits F.
- Score: pulse match_pulse 101 times in PLAY → score steps 09→10 correctly and saturates at hex5/hex4=9/9.
- Lives (LIVES=3): 3 miss_pulses → ledrhldr 0x7→0x3→0x1, then OVER. Match + miss on the final miss cycle → score incremented and OVER entered.
- Flash (FLASH_DIV=2): in OVER, ledrhldr = 3FF, 3FF, 000, 000, 3FF…. Start → PLAY with score 00 and full lives.
- Quit priority: quit with match_pulse in PLAY → QUIT, userquit=1, all digits F, score unchanged internally. start → IDLE, hex0hldr=0.

Source files
------------

// File: rtl/game_status_ctrl.sv
// -----------------------------------------------------------------------------
// game_status_ctrl
//   Game-level controller for the tile-matching game. Converts start/quit/
//   match/miss event pulses into a game mode, a BCD score, a BCD countdown
//   timer and a lives bar, and drives the holder inputs of the board display
//   stage. Every output comes straight from a flop.
//
// Ports
//   CLOCK_50     in   1   system clock, rising edge
//   resetn       in   1   asynchronous active-low reset
//   start        in   1   one-cycle pulse: start / restart / leave QUIT
//   quit         in   1   one-cycle pulse: abandon game
//   match_pulse  in   1   one-cycle pulse: pair matched (score +1)
//   miss_pulse   in   1   one-cycle pulse: pair mismatched (lives -1)
//   userquit     out  1   high in QUIT
//   ingameOn     out  1   high in PLAY
//   gameOver     out  1   high in OVER
//   hex0hldr     out  4   mode code IDLE=0 PLAY=1 OVER=2 QUIT=3
//   hex2hldr     out  4   timer ones digit (4'hF = blank)
//   hex3hldr     out  4   timer tens digit (4'hF = blank)
//   hex4hldr     out  4   score ones digit (4'hF = blank)
//   hex5hldr     out  4   score tens digit (4'hF = blank)
//   ledrhldr     out  10  lives thermometer in PLAY, flash pattern in OVER
// -----------------------------------------------------------------------------
module game_status_ctrl #(
    parameter int TICK_DIV     = 50000000,
    parameter int GAME_SECONDS = 60,
    parameter int LIVES        = 10,
    parameter int FLASH_DIV    = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic       quit,
    input  logic       match_pulse,
    input  logic       miss_pulse,
    output logic       userquit,
    output logic       ingameOn,
    output logic       gameOver,
    output logic [3:0] hex0hldr,
    output logic [3:0] hex2hldr,
    output logic [3:0] hex3hldr,
    output logic [3:0] hex4hldr,
    output logic [3:0] hex5hldr,
    output logic [9:0] ledrhldr
);

    localparam int PW = (TICK_DIV  > 2) ? $clog2(TICK_DIV)  : 1;
    localparam int FW = (FLASH_DIV > 2) ? $clog2(FLASH_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_MAX  = FW'(FLASH_DIV - 1);
    localparam logic [3:0]    GS_TENS    = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]    GS_ONES    = 4'(GAME_SECONDS % 10);
    localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
    localparam logic [3:0]    BLANK      = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2,
        ST_QUIT = 2'd3
    } state_t;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] r;
        if (tens == 4'd9 && ones == 4'd9) begin
            r = {tens, ones};
        end else if (ones == 4'd9) begin
            r = {tens + 4'd1, 4'd0};
        end else begin
            r = {tens, ones + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD decrement with borrow, floor at 00.
    function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] r;
        if (ones != 4'd0) begin
            r = {tens, ones - 4'd1};
        end else if (tens != 4'd0) begin
            r = {tens - 4'd1, 4'd9};
        end else begin
            r = 8'h00;
        end
        return r;
    endfunction

    // Lower n bits set.
    function automatic logic [9:0] lives_bar(input logic [3:0] n);
        logic [9:0] bar;
        bar = 10'd0;
        for (int i = 0; i < 10; i++) begin
            if (4'(i) < n) begin
                bar[i] = 1'b1;
            end else begin
                bar[i] = 1'b0;
            end
        end
        return bar;
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    score_t_q, score_t_d, score_o_q, score_o_d;
    logic [3:0]    timer_t_q, timer_t_d, timer_o_q, timer_o_d;
    logic [3:0]    lives_q, lives_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic          flash_on_q, flash_on_d;

    logic          userquit_q, userquit_d;
    logic          ingame_q, ingame_d;
    logic          gameover_q, gameover_d;
    logic [3:0]    hex0_q, hex0_d, hex2_q, hex2_d, hex3_q, hex3_d;
    logic [3:0]    hex4_q, hex4_d, hex5_q, hex5_d;
    logic [9:0]    ledr_q, ledr_d;

    logic          load_s;
    logic          tick_s;
    logic [7:0]    score_inc_s;
    logic [7:0]    timer_dec_s;

    assign score_inc_s = bcd_inc_sat(score_t_q, score_o_q);
    assign timer_dec_s = bcd_dec(timer_t_q, timer_o_q);
    assign tick_s      = (presc_q == PRESC_MAX);

    // Next-state and datapath update for the game FSM.
    always_comb begin
        state_d     = state_q;
        score_t_d   = score_t_q;
        score_o_d   = score_o_q;
        timer_t_d   = timer_t_q;
        timer_o_d   = timer_o_q;
        lives_d     = lives_q;
        presc_d     = presc_q;
        flash_cnt_d = flash_cnt_q;
        flash_on_d  = flash_on_q;
        load_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (quit) begin
                    state_d = ST_QUIT;
                end else if (start) begin
                    state_d = ST_PLAY;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (quit) begin
                    // Same-cycle match/miss/tick are deliberately dropped.
                    state_d = ST_QUIT;
                end else begin
                    if (match_pulse) begin
                        {score_t_d, score_o_d} = score_inc_s;
                    end else begin
                        {score_t_d, score_o_d} = {score_t_q, score_o_q};
                    end
                    if (miss_pulse && lives_q != 4'd0) begin
                        lives_d = lives_q - 4'd1;
                    end else begin
                        lives_d = lives_q;
                    end
                    if (tick_s) begin
                        presc_d                = {PW{1'b0}};
                        {timer_t_d, timer_o_d} = timer_dec_s;
                    end else begin
                        presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
                    end
                    // Game ends on the edge that removes the last life or
                    // counts the timer down to 00; the final values are kept.
                    if ((miss_pulse && lives_q == 4'd1) ||
                        (tick_s && timer_dec_s == 8'h00)) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_OVER: begin
                if (quit) begin
                    state_d = ST_QUIT;
                end else if (start) begin
                    state_d = ST_PLAY;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_OVER;
                    if (flash_cnt_q == FLASH_MAX) begin
                        flash_cnt_d = {FW{1'b0}};
                        flash_on_d  = ~flash_on_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + {{(FW-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_QUIT: begin
                if (start) begin
                    state_d   = ST_IDLE;
                    score_t_d = 4'd0;
                    score_o_d = 4'd0;
                    lives_d   = 4'd0;
                end else begin
                    state_d = ST_QUIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            score_t_d = 4'd0;
            score_o_d = 4'd0;
            timer_t_d = GS_TENS;
            timer_o_d = GS_ONES;
            lives_d   = LIVES_INIT;
        end else begin
            lives_d = lives_d;
        end

        // Every state change (including OVER->PLAY restart) restarts the
        // prescaler and the flash sequence; the flash begins all-on.
        if (state_d != state_q) begin
            presc_d     = {PW{1'b0}};
            flash_cnt_d = {FW{1'b0}};
            flash_on_d  = 1'b1;
        end else begin
            flash_on_d = flash_on_d;
        end
    end

    // Output decode from the next-state values so outputs track their flops
    // with one cycle of latency from the input event.
    always_comb begin
        userquit_d = 1'b0;
        ingame_d   = 1'b0;
        gameover_d = 1'b0;
        hex0_d     = {2'b00, state_d};
        hex2_d     = BLANK;
        hex3_d     = BLANK;
        hex4_d     = BLANK;
        hex5_d     = BLANK;
        ledr_d     = 10'd0;

        case (state_d)
            ST_PLAY: begin
                ingame_d = 1'b1;
                hex5_d   = score_t_d;
                hex4_d   = score_o_d;
                hex3_d   = timer_t_d;
                hex2_d   = timer_o_d;
                ledr_d   = lives_bar(lives_d);
            end
            ST_OVER: begin
                gameover_d = 1'b1;
                hex5_d     = score_t_d;
                hex4_d     = score_o_d;
                ledr_d     = flash_on_d ? 10'h3FF : 10'h000;
            end
            ST_QUIT: begin
                userquit_d = 1'b1;
            end
            ST_IDLE: begin
                userquit_d = 1'b0;
            end
            default: begin
                userquit_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            score_t_q   <= 4'd0;
            score_o_q   <= 4'd0;
            timer_t_q   <= 4'd0;
            timer_o_q   <= 4'd0;
            lives_q     <= 4'd0;
            presc_q     <= {PW{1'b0}};
            flash_cnt_q <= {FW{1'b0}};
            flash_on_q  <= 1'b0;
            userquit_q  <= 1'b0;
            ingame_q    <= 1'b0;
            gameover_q  <= 1'b0;
            hex0_q      <= 4'd0;
            hex2_q      <= BLANK;
            hex3_q      <= BLANK;
            hex4_q      <= BLANK;
            hex5_q      <= BLANK;
            ledr_q      <= 10'd0;
        end else begin
            state_q     <= state_d;
            score_t_q   <= score_t_d;
            score_o_q   <= score_o_d;
            timer_t_q   <= timer_t_d;
            timer_o_q   <= timer_o_d;
            lives_q     <= lives_d;
            presc_q     <= presc_d;
            flash_cnt_q <= flash_cnt_d;
            flash_on_q  <= flash_on_d;
            userquit_q  <= userquit_d;
            ingame_q    <= ingame_d;
            gameover_q  <= gameover_d;
            hex0_q      <= hex0_d;
            hex2_q      <= hex2_d;
            hex3_q      <= hex3_d;
            hex4_q      <= hex4_d;
            hex5_q      <= hex5_d;
            ledr_q      <= ledr_d;
        end
    end

    assign userquit = userquit_q;
    assign ingameOn = ingame_q;
    assign gameOver = gameover_q;
    assign hex0hldr = hex0_q;
    assign hex2hldr = hex2_q;
    assign hex3hldr = hex3_q;
    assign hex4hldr = hex4_q;
    assign hex5hldr = hex5_q;
    assign ledrhldr = ledr_q;

endmodule

// File: tb/tb_game_status_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_status_ctrl
//   Directed bench for game_status_ctrl. Two instances with small parameters:
//     u_a: TICK_DIV=4, GAME_SECONDS=12, LIVES=10, FLASH_DIV=2 (timer, flash,
//          quit priority, async reset)
//     u_b: TICK_DIV=3, GAME_SECONDS=40, LIVES=3,  FLASH_DIV=1 (lives, score)
//   Stimulus pushes expected output vectors, tagged with the cycle at which
//   they must appear, into per-instance queues; a negedge monitor pops and
//   compares them.
// -----------------------------------------------------------------------------
module tb_game_status_ctrl;

    localparam logic [3:0] BL = 4'hF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic a_start, a_quit, a_match, a_miss;
    logic b_start, b_quit, b_match, b_miss;
    logic a_uq, a_ig, a_go, b_uq, b_ig, b_go;
    logic [3:0] a_h0, a_h2, a_h3, a_h4, a_h5, b_h0, b_h2, b_h3, b_h4, b_h5;
    logic [9:0] a_led, b_led;
    logic [32:0] a_vec, b_vec;

    assign a_vec = {a_uq, a_ig, a_go, a_h0, a_h2, a_h3, a_h4, a_h5, a_led};
    assign b_vec = {b_uq, b_ig, b_go, b_h0, b_h2, b_h3, b_h4, b_h5, b_led};

    game_status_ctrl #(.TICK_DIV(4), .GAME_SECONDS(12), .LIVES(10), .FLASH_DIV(2)) u_a (
        .CLOCK_50(clk), .resetn(resetn), .start(a_start), .quit(a_quit),
        .match_pulse(a_match), .miss_pulse(a_miss),
        .userquit(a_uq), .ingameOn(a_ig), .gameOver(a_go), .hex0hldr(a_h0),
        .hex2hldr(a_h2), .hex3hldr(a_h3), .hex4hldr(a_h4), .hex5hldr(a_h5),
        .ledrhldr(a_led)
    );

    game_status_ctrl #(.TICK_DIV(3), .GAME_SECONDS(40), .LIVES(3), .FLASH_DIV(1)) u_b (
        .CLOCK_50(clk), .resetn(resetn), .start(b_start), .quit(b_quit),
        .match_pulse(b_match), .miss_pulse(b_miss),
        .userquit(b_uq), .ingameOn(b_ig), .gameOver(b_go), .hex0hldr(b_h0),
        .hex2hldr(b_h2), .hex3hldr(b_h3), .hex4hldr(b_h4), .hex5hldr(b_h5),
        .ledrhldr(b_led)
    );

    typedef struct {
        int          tag;
        string       name;
        logic [32:0] vec;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected output vector; flags are implied by the mode code.
    function automatic logic [32:0] mk(input logic [1:0] mode, input logic [3:0] tt,
                                       input logic [3:0] to, input logic [3:0] st,
                                       input logic [3:0] so, input logic [9:0] led);
        return {mode == 2'd3, mode == 2'd1, mode == 2'd2, {2'b00, mode}, to, tt, so, st, led};
    endfunction

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic exp_a(input int n, input string name, input logic [32:0] v);
        exp_t e;
        e.tag = cyc + n; e.name = name; e.vec = v;
        qa.push_back(e);
    endtask

    task automatic exp_b(input int n, input string name, input logic [32:0] v);
        exp_t e;
        e.tag = cyc + n; e.name = name; e.vec = v;
        qb.push_back(e);
    endtask

    task automatic cyc_a(input logic s, input logic q, input logic m, input logic x);
        a_start = s; a_quit = q; a_match = m; a_miss = x;
        @(negedge clk);
        a_start = 1'b0; a_quit = 1'b0; a_match = 1'b0; a_miss = 1'b0;
    endtask

    task automatic cyc_b(input logic s, input logic q, input logic m, input logic x);
        b_start = s; b_quit = q; b_match = m; b_miss = x;
        @(negedge clk);
        b_start = 1'b0; b_quit = 1'b0; b_match = 1'b0; b_miss = 1'b0;
    endtask

    // Monitor: compare every expectation that falls due at this cycle.
    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].tag <= cyc) begin
            ea = qa.pop_front();
            if (ea.tag == cyc) begin
                check(ea.name, a_vec, ea.vec);
            end else begin
                n_chk++;
                $display("FAIL %s: due cycle %0d missed, now %0d", ea.name, ea.tag, cyc);
            end
        end
        while (qb.size() > 0 && qb[0].tag <= cyc) begin
            eb = qb.pop_front();
            if (eb.tag == cyc) begin
                check(eb.name, b_vec, eb.vec);
            end else begin
                n_chk++;
                $display("FAIL %s: due cycle %0d missed, now %0d", eb.name, eb.tag, cyc);
            end
        end
    end

    logic [32:0] idle_v, quit_v;
    int t, s;

    initial begin
        idle_v = mk(2'd0, BL, BL, BL, BL, 10'h000);
        quit_v = mk(2'd3, BL, BL, BL, BL, 10'h000);
        resetn = 1'b0;
        a_start = 1'b0; a_quit = 1'b0; a_match = 1'b0; a_miss = 1'b0;
        b_start = 1'b0; b_quit = 1'b0; b_match = 1'b0; b_miss = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_a", a_vec, idle_v);
        check("rst_b", b_vec, idle_v);
        resetn = 1'b1;
        exp_a(1, "a_idle", idle_v);
        exp_b(1, "b_idle", idle_v);
        @(negedge clk);

        // ---- timer countdown and flash on u_a ----
        exp_a(1, "a_start", mk(2'd1, 4'd1, 4'd2, 4'd0, 4'd0, 10'h3FF));
        cyc_a(1'b1, 1'b0, 1'b0, 1'b0);
        exp_a(3,  "a_t12_hold", mk(2'd1, 4'd1, 4'd2, 4'd0, 4'd0, 10'h3FF));
        exp_a(4,  "a_t11",      mk(2'd1, 4'd1, 4'd1, 4'd0, 4'd0, 10'h3FF));
        exp_a(12, "a_t09",      mk(2'd1, 4'd0, 4'd9, 4'd0, 4'd0, 10'h3FF));
        exp_a(47, "a_t01",      mk(2'd1, 4'd0, 4'd1, 4'd0, 4'd0, 10'h3FF));
        exp_a(48, "a_over",     mk(2'd2, BL, BL, 4'd0, 4'd0, 10'h3FF));
        exp_a(49, "a_flash1",   mk(2'd2, BL, BL, 4'd0, 4'd0, 10'h3FF));
        exp_a(50, "a_flash2",   mk(2'd2, BL, BL, 4'd0, 4'd0, 10'h000));
        exp_a(51, "a_flash3",   mk(2'd2, BL, BL, 4'd0, 4'd0, 10'h000));
        exp_a(52, "a_flash4",   mk(2'd2, BL, BL, 4'd0, 4'd0, 10'h3FF));
        repeat (52) @(negedge clk);
        exp_a(1, "a_over_ign", mk(2'd2, BL, BL, 4'd0, 4'd0, 10'h3FF));
        cyc_a(1'b0, 1'b0, 1'b1, 1'b1);

        // ---- restart, score, match+miss, quit priority ----
        exp_a(1, "a_restart", mk(2'd1, 4'd1, 4'd2, 4'd0, 4'd0, 10'h3FF));
        cyc_a(1'b1, 1'b0, 1'b0, 1'b0);
        exp_a(1, "a_match1", mk(2'd1, 4'd1, 4'd2, 4'd0, 4'd1, 10'h3FF));
        cyc_a(1'b0, 1'b0, 1'b1, 1'b0);
        exp_a(1, "a_match_miss", mk(2'd1, 4'd1, 4'd2, 4'd0, 4'd2, 10'h1FF));
        cyc_a(1'b0, 1'b0, 1'b1, 1'b1);
        exp_a(1, "a_quit_match", quit_v);
        cyc_a(1'b0, 1'b1, 1'b1, 1'b0);
        exp_a(1, "a_quit_startq", idle_v);
        cyc_a(1'b1, 1'b1, 1'b0, 1'b0);
        exp_a(1, "a_idle_startq", quit_v);
        cyc_a(1'b1, 1'b1, 1'b0, 1'b0);
        exp_a(1, "a_quit_to_idle", idle_v);
        cyc_a(1'b1, 1'b0, 1'b0, 1'b0);
        exp_a(1, "a_idle_ign", idle_v);
        cyc_a(1'b0, 1'b0, 1'b1, 1'b1);
        exp_a(1, "a_play_fresh", mk(2'd1, 4'd1, 4'd2, 4'd0, 4'd0, 10'h3FF));
        cyc_a(1'b1, 1'b0, 1'b0, 1'b0);
        exp_a(1, "a_start_ign", mk(2'd1, 4'd1, 4'd2, 4'd0, 4'd0, 10'h3FF));
        cyc_a(1'b1, 1'b0, 1'b0, 1'b0);

        // ---- asynchronous reset mid-PLAY, no clock edge ----
        #2 resetn = 1'b0;
        #1;
        check("async_rst_a", a_vec, idle_v);
        check("async_rst_b", b_vec, idle_v);
        @(negedge clk);
        resetn = 1'b1;
        exp_a(1, "a_post_rst", idle_v);
        @(negedge clk);

        // ---- lives and same-cycle match on final miss (u_b) ----
        exp_b(1, "b_start", mk(2'd1, 4'd4, 4'd0, 4'd0, 4'd0, 10'h007));
        cyc_b(1'b1, 1'b0, 1'b0, 1'b0);
        exp_b(1, "b_miss1", mk(2'd1, 4'd4, 4'd0, 4'd0, 4'd0, 10'h003));
        cyc_b(1'b0, 1'b0, 1'b0, 1'b1);
        exp_b(1, "b_miss2", mk(2'd1, 4'd4, 4'd0, 4'd0, 4'd0, 10'h001));
        cyc_b(1'b0, 1'b0, 1'b0, 1'b1);
        exp_b(1, "b_miss3_match", mk(2'd2, BL, BL, 4'd0, 4'd1, 10'h3FF));
        cyc_b(1'b0, 1'b0, 1'b1, 1'b1);
        exp_b(1, "b_flash_off", mk(2'd2, BL, BL, 4'd0, 4'd1, 10'h000));
        exp_b(2, "b_flash_on",  mk(2'd2, BL, BL, 4'd0, 4'd1, 10'h3FF));
        repeat (2) @(negedge clk);
        exp_b(1, "b_restart", mk(2'd1, 4'd4, 4'd0, 4'd0, 4'd0, 10'h007));
        cyc_b(1'b1, 1'b0, 1'b0, 1'b0);

        // ---- 101 consecutive matches: BCD carry and saturation ----
        for (int k = 1; k <= 101; k++) begin
            s = (k > 99) ? 99 : k;
            t = 40 - (k / 3);
            exp_b(1, $sformatf("b_score%0d", k),
                  mk(2'd1, 4'(t / 10), 4'(t % 10), 4'(s / 10), 4'(s % 10), 10'h007));
            b_match = 1'b1;
            @(negedge clk);
        end
        b_match = 1'b0;
        exp_b(1, "b_quit", quit_v);
        cyc_b(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        n_chk++;
        if (qa.size() == 0 && qb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL queues_drained: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
